spi_mmio_bridge: RTL and testbench
==================================

# spi_mmio_bridge

SPI slave front-end that turns MCU serial frames into the 8-bit parallel register-bus strobes (cs/rd/wr/addr/wdata) consumed by the coprocessor's MMIO register shadow. Sits between the MCU SPI pins and the MMIO register block, in the coprocessor clock domain. SCLK is oversampled rather than used as a clock, so the whole block is single-clock.

## Interface
- CMD_WR, 8'h02: write opcode (first frame byte).
- CMD_RD, 8'h03: read opcode.
- clk  in  1  coprocessor clock; must be at least 16x the SCLK frequency.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- ss_n  in  1  SPI slave select, active low, asynchronous.
- mosi  in  1  SPI data in, MSB first, asynchronous.
- miso  out  1  SPI data out, MSB first.
- miso_oe  out  1  output enable for the MISO pad (1 = drive).
- cs  out  1  bus select; high only together with rd or wr.
- rd  out  1  one-cycle read strobe.
- wr  out  1  one-cycle write strobe.
- addr  out  8  bus address; held stable between strobes.
- wdata  out  8  write data; held stable between strobes.
- rdata  in  8  read data. Combinational from the MMIO block and valid in the same cycle as cs&&rd.

## Operation
- Frame: ss_n low, then CMD byte, ADDR byte, DATA byte, each MSB first. The frame ends when ss_n goes high.
- sclk, ss_n and mosi each pass through a 2-FF synchronizer. Rising and falling SCLK edges are detected on the synchronized signal.
- mosi is sampled on each synchronized SCLK rising edge into an 8-bit shift register. A 3-bit bit counter tracks position within the byte.
- FSM states:
  - IDLE: waits for ss_n low, then goes to CMD.
  - CMD: after 8 bits, goes to ADDR if the byte is CMD_WR or CMD_RD; any other byte goes to DISCARD.
  - ADDR: after 8 bits, latches addr. For a read, issues cs=rd=1 for one cycle, captures rdata into the TX shift register and goes to DATA. For a write, goes to DATA with no strobe.
  - DATA: for a write, after 8 bits latches wdata and issues cs=wr=1 for one cycle.
  - DISCARD: ignores everything until ss_n goes high. No strobes; miso=0.
  - From any state, synchronized ss_n high returns to IDLE and clears the bit counter.
- MISO:
  - miso_oe=1 whenever synchronized ss_n is low.
  - miso = TX register MSB. The TX register shifts left on each synchronized SCLK falling edge, but only in the DATA state of a read.
  - miso=0 in all other states.
- Extra bytes after DATA (macro undefined): ignored, no strobes, miso=0.
- Reset values: cs=0, rd=0, wr=0, addr=8'h00, wdata=8'h00, miso=0, miso_oe=0, FSM=IDLE.

## Timing
- Strobe latency: each strobe goes high exactly 4 clk after the qualifying SCLK rising edge at the pin (16th edge for rd, 24th for wr). It lasts exactly 1 clk.
- addr and wdata are updated in the same cycle the strobe rises and hold until the next update.
- Read: the TX register is loaded in the rd cycle, so miso carries data MSB 1 clk later. This is before the 17th SCLK rising edge, given the clk ≥ 16x SCLK rule.
- Abort: ss_n rising before the 24th edge of a write gives no wr. ss_n rising after the read strobe has no further effect on the bus.
- Mid-frame rst_n: everything returns to reset values immediately and no strobe is emitted. A frame still in progress after reset release is ignored until ss_n has been seen high.
- At most one strobe per clk; rd and wr are never high together.

## Configuration
- SPI_BURST_EN defined:
  - While ss_n stays low after DATA, each further byte continues the transaction at addr+1. Address wraps 8'hFF to 8'h00.
  - Write: each completed byte gives a wr strobe at the incremented address.
  - Read: after the 8th rising edge of each data byte, the next rd at addr+1 is issued and the TX register reloaded, so the following byte streams the next register.
- SPI_BURST_EN undefined: single-byte transactions only, as in Operation.

## Structure
- Shared package mmio_pkg holds:
  - CMD_WR and CMD_RD opcodes.
  - FSM state encoding.
  - MMIO address constants (STATUS 8'h00, CTRL 8'h01, T 8'h02, dT 8'h03, G 8'h04, threshold bases 8'h10 and 8'h1C).
- One sub-module: spi_sync. It is the 2-FF synchronizer plus rise/fall edge detector and is instantiated for sclk, plus plain synchronizers for ss_n and mosi.

## Test plan
- Write frame 02 02 19 (SCLK = clk/16): exactly one wr cycle with addr=8'h02, wdata=8'h19, cs=1, rd=0.
- Read frame 03 04 xx with rdata model returning 8'h37 at addr 8'h04: one rd cycle at addr 8'h04, master captures 8'h37 on MISO.
- ss_n raised after 20 bits of frame 02 10 AA: no wr, FSM back in IDLE, next full frame works.
- Bad opcode 55 10 AA: no strobes, miso=0 throughout, miso_oe=1 while ss_n is low.
- rst_n pulsed mid-ADDR byte: all outputs at reset values, no strobe until a fresh frame after ss_n has gone high.
- SPI_BURST_EN: frame 02 FF 11 22 gives wr at 8'hFF (data 11) then at 8'h00 (data 22). Frame 03 04 xx xx gives rd at 04 then 05.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: opcodes, bridge FSM encoding and MMIO register map shared by the
// SPI bridge and the register shadow.
package mmio_pkg;

    // Frame opcodes (first byte of every SPI frame)
    localparam logic [7:0] CMD_WR = 8'h02;
    localparam logic [7:0] CMD_RD = 8'h03;

    // MMIO register map
    localparam logic [7:0] ADDR_STATUS   = 8'h00;
    localparam logic [7:0] ADDR_CTRL     = 8'h01;
    localparam logic [7:0] ADDR_T        = 8'h02;
    localparam logic [7:0] ADDR_DT       = 8'h03;
    localparam logic [7:0] ADDR_G        = 8'h04;
    localparam logic [7:0] ADDR_THR_BASE = 8'h10;
    localparam logic [7:0] ADDR_HYS_BASE = 8'h1C;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StDiscard
    } spi_state_e;

    function automatic logic is_valid_cmd(input logic [7:0] b);
        return (b == CMD_WR) || (b == CMD_RD);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-FF synchronizer for an asynchronous SPI pin plus registered
// one-cycle rise/fall pulses taken on the synchronized level.
module spi_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    // [0] metastable stage, [1] synchronized level, [2] previous level
    logic [2:0] sync_q;

    // Synchronize and register the edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d};
            rise   <= sync_q[1] & ~sync_q[2];
            fall   <= ~sync_q[1] & sync_q[2];
        end
    end

endmodule

// File: rtl/spi_mmio_bridge.sv
// spi_mmio_bridge: SPI mode-0 slave that turns CMD/ADDR/DATA frames into
// one-cycle cs/rd/wr strobes on the 8-bit MMIO register bus. SCLK is
// oversampled, so the block runs entirely on clk.
// Build option: define SPI_BURST_EN for auto-incrementing multi-byte frames.
module spi_mmio_bridge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    input  logic [7:0] rdata
);
    import mmio_pkg::*;

    logic       sclk_rise, sclk_fall;
    logic [1:0] ss_sync_q, mosi_sync_q, settle_q;
    logic       ss_s, mosi_s;

    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, tx_q, tx_d, tgt_q, tgt_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
    logic       is_rd_q, is_rd_d, rd_q, rd_d, wr_q, wr_d, armed_q, armed_d;
    logic       byte_done;
    logic [7:0] rx_byte;

    spi_sync u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Plain synchronizers; ss_n resets to its deasserted level. settle_q marks
    // when the ss_n synchronizer holds a real pin sample after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            settle_q    <= 2'b00;
        end else begin
            ss_sync_q   <= {ss_sync_q[0], ss_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            settle_q    <= {settle_q[0], 1'b1};
        end
    end

    assign ss_s   = ss_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    // FSM and datapath state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'h00;
            tgt_q     <= 8'h00;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            is_rd_q   <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            tgt_q     <= tgt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_rd_q   <= is_rd_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            armed_q   <= armed_d;
        end
    end

    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {shift_q[6:0], mosi_s};

    // Next-state: frame decode, strobe generation and MISO shifting
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        tgt_d     = tgt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_rd_d   = is_rd_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        // A frame already running at reset release is ignored until ss_n is seen high
        armed_d   = armed_q | (settle_q[1] & ss_s);

        // Load in the rd cycle; the falling edge that closes the address byte
        // (bit count still 0) must not shift out the fresh MSB.
        if (rd_q) begin
            tx_d = rdata;
        end else if (state_q == StData && is_rd_q && sclk_fall && bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end

        if (ss_s) begin
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
        end else begin
            if (sclk_rise && state_q != StIdle) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (armed_q) state_d = StCmd;
                end
                StCmd: begin
                    if (byte_done) begin
                        is_rd_d = (rx_byte == CMD_RD);
                        state_d = is_valid_cmd(rx_byte) ? StAddr : StDiscard;
                    end
                end
                StAddr: begin
                    if (byte_done) begin
                        if (is_rd_q) begin
                            rd_d   = 1'b1;
                            addr_d = rx_byte;
                            tgt_d  = rx_byte + 8'd1;
                        end else begin
                            tgt_d  = rx_byte;
                        end
                        state_d = StData;
                    end
                end
                StData: begin
                    if (byte_done) begin
                        if (is_rd_q) begin
`ifdef SPI_BURST_EN
                            rd_d   = 1'b1;
                            addr_d = tgt_q;
                            tgt_d  = tgt_q + 8'd1;
`else
                            state_d = StDiscard;
`endif
                        end else begin
                            wr_d    = 1'b1;
                            addr_d  = tgt_q;
                            wdata_d = rx_byte;
                            tgt_d   = tgt_q + 8'd1;
`ifndef SPI_BURST_EN
                            state_d = StDiscard;
`endif
                        end
                    end
                end
                StDiscard: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign cs      = rd_q | wr_q;
    assign rd      = rd_q;
    assign wr      = wr_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;
    assign miso_oe = ~ss_s;
    assign miso    = (state_q == StData && is_rd_q) ? tx_q[7] : 1'b0;

endmodule

// File: tb/tb_spi_mmio_bridge.sv
// tb_spi_mmio_bridge: drives SPI mode-0 frames (SCLK = clk/16) and compares
// bus strobes, their latency and MISO bytes against a frame-level model.
`timescale 1ns/1ps
module tb_spi_mmio_bridge;

`ifdef SPI_BURST_EN
    localparam bit Burst = 1'b1;
`else
    localparam bit Burst = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic       miso, miso_oe, cs, rd, wr;
    logic [7:0] addr, wdata, rdata;
    logic [7:0] mem [256];

    assign rdata = mem[addr];

    spi_mmio_bridge dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .cs      (cs),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [7:0]  a;
        logic [7:0]  d;
        int unsigned t;
    } strobe_t;

    int unsigned n_checks = 0, n_errors = 0;
    int unsigned cyc = 0;
    int unsigned quiet_bad = 0;
    bit          quiet_mon = 1'b0;
    strobe_t     obs_q[$];
    int unsigned edge_t[$];
    logic [7:0]  miso_bytes[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: log every strobe cycle, sampled on the falling clk edge
    always @(negedge clk) begin
        if (rst_n && (cs || rd || wr)) begin
            check("cs_with_strobe", {31'd0, cs}, {31'd0, rd | wr});
            check("rd_wr_excl", {31'd0, rd & wr}, 32'd0);
            obs_q.push_back('{rd, addr, wdata, cyc});
        end
        if (quiet_mon && miso !== 1'b0) quiet_bad++;
    end

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        logic [7:0] rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            edge_t.push_back(cyc);
            rx = {rx[6:0], miso};
            check("miso_oe", {31'd0, miso_oe}, 32'd1);
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        if (nbits == 8) miso_bytes.push_back(rx);
    endtask

    task automatic ss_end();
        repeat (8) @(negedge clk);
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Frame-level reference: which strobes a frame of nbits must produce,
    // when, and what the master must read back on MISO.
    task automatic check_frame(input logic [7:0] fb[$], input int nbits, input string tag);
        strobe_t    exp_q[$];
        int         nfull  = nbits / 8;
        bit         is_rd  = (fb[0] == 8'h03);
        bit         ok_cmd = (fb[0] == 8'h02) || (fb[0] == 8'h03);
        logic [7:0] a;
        logic [7:0] em;
        if (ok_cmd && nfull >= 2) begin
            if (is_rd) begin
                for (int j = 0; j < (Burst ? nfull - 1 : 1); j++) begin
                    a = fb[1] + 8'(j);
                    exp_q.push_back('{1'b1, a, 8'h00, edge_t[15 + 8 * j] + 4});
                end
            end else begin
                for (int j = 0; j < nfull - 2 && (Burst || j == 0); j++) begin
                    a = fb[1] + 8'(j);
                    exp_q.push_back('{1'b0, a, fb[2 + j], edge_t[23 + 8 * j] + 4});
                end
            end
        end
        check({tag, ":n_strobes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, ":kind"}, {31'd0, obs_q[i].is_rd}, {31'd0, exp_q[i].is_rd});
            check({tag, ":addr"}, {24'd0, obs_q[i].a}, {24'd0, exp_q[i].a});
            check({tag, ":latency"}, obs_q[i].t, exp_q[i].t);
            if (!exp_q[i].is_rd) check({tag, ":wdata"}, {24'd0, obs_q[i].d}, {24'd0, exp_q[i].d});
        end
        for (int k = 0; k < miso_bytes.size(); k++) begin
            em = 8'h00;
            if (ok_cmd && is_rd && k >= 2 && (Burst || k == 2)) em = mem[fb[1] + 8'(k - 2)];
            check({tag, ":miso"}, {24'd0, miso_bytes[k]}, {24'd0, em});
        end
    endtask

    task automatic run_frame(input logic [7:0] fb[$], input int nbits, input string tag);
        int left = nbits;
        obs_q.delete();
        edge_t.delete();
        miso_bytes.delete();
        @(negedge clk);
        ss_n = 1'b0;
        foreach (fb[i]) begin
            if (left > 0) spi_bits(fb[i], (left >= 8) ? 8 : left);
            left -= 8;
        end
        ss_end();
        check_frame(fb, nbits, tag);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, ":cs"}, {31'd0, cs}, 32'd0);
        check({tag, ":rd"}, {31'd0, rd}, 32'd0);
        check({tag, ":wr"}, {31'd0, wr}, 32'd0);
        check({tag, ":addr"}, {24'd0, addr}, 32'd0);
        check({tag, ":wdata"}, {24'd0, wdata}, 32'd0);
        check({tag, ":miso"}, {31'd0, miso}, 32'd0);
        check({tag, ":miso_oe"}, {31'd0, miso_oe}, 32'd0);
    endtask

    initial begin
        logic [7:0] f[$];
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h04] = 8'h37;

        repeat (3) @(negedge clk);
        reset_vals("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        f = '{8'h02, 8'h02, 8'h19};
        run_frame(f, 24, "write");
        f = '{8'h03, 8'h04, 8'h00};
        run_frame(f, 24, "read");
        f = '{8'h02, 8'h10, 8'hAA};
        run_frame(f, 20, "abort");
        f = '{8'h02, 8'h11, 8'h5C};
        run_frame(f, 24, "after_abort");

        quiet_bad = 0;
        quiet_mon = 1'b1;
        f = '{8'h55, 8'h10, 8'hAA};
        run_frame(f, 24, "bad_op");
        quiet_mon = 1'b0;
        check("bad_op:miso_quiet", quiet_bad, 32'd0);

        f = '{8'h02, 8'hFF, 8'h11, 8'h22};
        run_frame(f, 32, "burst_wr");
        f = '{8'h03, 8'h04, 8'h00, 8'h00};
        run_frame(f, 32, "burst_rd");

        // Randomized frames: valid and invalid opcodes, varying length, truncation
        for (int n = 0; n < 30; n++) begin
            int         nb  = int'($urandom_range(2, 5));
            int         sel = int'($urandom_range(0, 3));
            int         bits;
            logic [7:0] c;
            c = 8'($urandom);
            if (c == 8'h02 || c == 8'h03) c = 8'hA5;
            if (sel < 2) c = 8'h02;
            else if (sel == 2) c = 8'h03;
            f.delete();
            f.push_back(c);
            for (int i = 1; i < nb; i++) f.push_back(8'($urandom));
            bits = nb * 8;
            if ($urandom_range(0, 3) == 0) bits = int'($urandom_range(1, nb * 8 - 1));
            run_frame(f, bits, "rand");
        end

        // Reset in the middle of the address byte, frame continues afterwards
        obs_q.delete();
        edge_t.delete();
        miso_bytes.delete();
        @(negedge clk);
        ss_n = 1'b0;
        spi_bits(8'h02, 8);
        spi_bits(8'h10, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_vals("rst_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        spi_bits(8'h10, 5);
        spi_bits(8'hAA, 8);
        spi_bits(8'h5A, 8);
        ss_end();
        check("rst_mid:no_strobe", obs_q.size(), 32'd0);
        check("rst_mid:addr_held", {24'd0, addr}, 32'd0);
        check("rst_mid:wdata_held", {24'd0, wdata}, 32'd0);
        f = '{8'h02, 8'h30, 8'hC3};
        run_frame(f, 24, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
